// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM state encodings and bus-level constants.
// Also used by the companion master so both sides agree on R/W and ACK polarity.
package i2c_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_RX       = 3'd3;
    localparam logic [2:0] ST_RX_ACK   = 3'd4;
    localparam logic [2:0] ST_TX       = 3'd5;
    localparam logic [2:0] ST_TX_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    localparam logic I2C_READ  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;

    // Busy covers every state in which this target owns the transaction.
    function automatic logic state_is_busy(input logic [2:0] st);
        return (st == ST_ADDR_ACK) || (st == ST_RX) || (st == ST_RX_ACK) ||
               (st == ST_TX) || (st == ST_TX_ACK);
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes one asynchronous bus line into clk and flags its rising/falling edges.
// The chain presets to 1 so an idle (pulled-up) bus produces no edge after reset.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // NOTE: registers use non-blocking assignments so every flop in the chain
    // samples the value from before this edge, giving a true shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit addressing, multi-byte write receive and read transmit.
// SDA is open-drain; sda_oe=1 pulls the line low and changes only on SCL falls.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h77,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic [2:0] state
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (scl_in),
        .level    (scl_level),
        .rise     (scl_rise),
        .fall     (scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sda_in),
        .level    (sda_level),
        .rise     (sda_rise),
        .fall     (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_level;
    assign stop_det  = sda_rise & scl_level;

    logic [2:0] bit_cnt;
    logic [7:0] shift_q;
    logic       rw_q;
    logic       byte_done;
    logic [7:0] rx_byte;

    assign rx_byte = {shift_q[6:0], sda_level};

    always_ff @(posedge clk) begin
        rx_valid <= 1'b0;
        tx_load  <= 1'b0;
        if (rst) begin
            state     <= ST_IDLE;
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            bit_cnt   <= 3'd0;
            shift_q   <= 8'h00;
            rw_q      <= I2C_WRITE;
            byte_done <= 1'b0;
        end else if (start_det) begin
            state     <= ST_ADDR;
            bit_cnt   <= 3'd0;
            sda_oe    <= 1'b0;
            byte_done <= 1'b0;
        end else if (stop_det) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            sda_oe    <= 1'b0;
            byte_done <= 1'b0;
        end else if (scl_rise) begin
            case (state)
                ST_ADDR: begin
                    shift_q <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rw_q  <= sda_level;
                        state <= (shift_q[6:0] == SLAVE_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                    end
                end
                ST_RX: begin
                    shift_q <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data  <= rx_byte;
                        rx_valid <= 1'b1;
                        state    <= ST_RX_ACK;
                    end
                end
                ST_TX: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) byte_done <= 1'b1;
                end
                ST_TX_ACK: begin
                    if (sda_level == NACK) begin
                        state  <= ST_IGNORE;
                        sda_oe <= 1'b0;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state)
                // The first fall after the 8th bit asserts ACK; the next one ends it.
                ST_ADDR_ACK: begin
                    if (!sda_oe) begin
                        sda_oe <= 1'b1;
                    end else if (rw_q == I2C_READ) begin
                        state   <= ST_TX;
                        shift_q <= tx_data;
                        tx_load <= 1'b1;
                        sda_oe  <= ~tx_data[7];
                        bit_cnt <= 3'd0;
                    end else begin
                        state   <= ST_RX;
                        sda_oe  <= 1'b0;
                        bit_cnt <= 3'd0;
                    end
                end
                ST_RX_ACK: begin
                    if (!sda_oe) begin
                        sda_oe <= 1'b1;
                    end else begin
                        state  <= ST_RX;
                        sda_oe <= 1'b0;
                    end
                end
                ST_TX: begin
                    if (byte_done) begin
                        state     <= ST_TX_ACK;
                        sda_oe    <= 1'b0;
                        byte_done <= 1'b0;
                    end else begin
                        shift_q <= {shift_q[6:0], 1'b0};
                        sda_oe  <= ~shift_q[6];
                    end
                end
                ST_TX_ACK: begin
                    state   <= ST_TX;
                    shift_q <= tx_data;
                    tx_load <= 1'b1;
                    sda_oe  <= ~tx_data[7];
                    bit_cnt <= 3'd0;
                end
                default: ;
            endcase
        end
    end

    assign busy = state_is_busy(state);

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: acts as an open-drain I2C master and checks
// the slave's ACKs, received/transmitted bytes, pulses and FSM state.
module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, tx_load, rx_valid, busy;
    logic [7:0] rx_data;
    logic [2:0] state;
    logic       sda_bus;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave #(.SLAVE_ADDR(7'h77), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .state    (state)
    );

    always #5 clk = ~clk;

    int unsigned rx_pulses = 0;
    int unsigned load_pulses = 0;
    int unsigned oe_cycles = 0;
    always @(posedge clk) begin
        if (rx_valid) rx_pulses <= rx_pulses + 1;
        if (tx_load) load_pulses <= load_pulses + 1;
        if (sda_oe) oe_cycles <= oe_cycles + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        if (scl == 1'b0) begin
            sda_m = 1'b1; wait_clk(8);
            scl = 1'b1;   wait_clk(8);
        end
        sda_m = 1'b0; wait_clk(8);
        scl = 1'b0;   wait_clk(4);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(8);
        scl = 1'b1;   wait_clk(8);
        sda_m = 1'b1; wait_clk(8);
    endtask

    // One SCL period: drive b while low, sample the wired bus mid-high.
    task automatic clock_bit(input logic b, output logic seen);
        sda_m = b;  wait_clk(8);
        scl = 1'b1; wait_clk(4);
        seen = sda_bus;
        wait_clk(4);
        scl = 1'b0; wait_clk(4);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], dummy);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic master_ack);
        logic b;
        logic dummy;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, b);
            d = {d[6:0], b};
        end
        clock_bit(master_ack, dummy);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack;
        logic       dummy;
        logic [7:0] rd;
        int unsigned rx0, ld0, oe0;

        // Reset state
        wait_clk(4);
        check("rst_state", state, 3'd0);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_load", tx_load, 1'b0);
        rst = 1'b0;
        wait_clk(8);
        check("idle_after_rst", state, 3'd0);

        // Write: EE, 5A
        rx0 = rx_pulses;
        bus_start();
        check("wr_start_addr", state, 3'd1);
        write_byte(8'hEE, ack);
        check("wr_addr_ack", ack, 1'b0);
        check("wr_state_rx", state, 3'd3);
        check("wr_busy", busy, 1'b1);
        write_byte(8'h5A, ack);
        check("wr_data_ack", ack, 1'b0);
        check("wr_rx_data", rx_data, 8'h5A);
        check("wr_rx_pulses", rx_pulses - rx0, 1);
        bus_stop();
        check("wr_end_idle", state, 3'd0);
        check("wr_end_busy", busy, 1'b0);

        // Read: EF, C3 (ACK), 3C (NACK)
        ld0 = load_pulses;
        tx_data = 8'hC3;
        bus_start();
        write_byte(8'hEF, ack);
        check("rd_addr_ack", ack, 1'b0);
        check("rd_state_tx", state, 3'd5);
        tx_data = 8'h3C;
        read_byte(rd, 1'b0);
        check("rd_byte0", rd, 8'hC3);
        read_byte(rd, 1'b1);
        check("rd_byte1", rd, 8'h3C);
        check("rd_nack_ignore", state, 3'd7);
        check("rd_nack_oe", sda_oe, 1'b0);
        check("rd_load_pulses", load_pulses - ld0, 2);
        bus_stop();
        check("rd_end_idle", state, 3'd0);

        // Address mismatch: A0
        oe0 = oe_cycles;
        bus_start();
        write_byte(8'hA0, ack);
        check("mm_no_ack", ack, 1'b1);
        check("mm_state_ignore", state, 3'd7);
        check("mm_busy", busy, 1'b0);
        wait_clk(20);
        check("mm_still_ignore", state, 3'd7);
        check("mm_oe_never", oe_cycles - oe0, 0);
        bus_stop();
        check("mm_end_idle", state, 3'd0);

        // Repeated START: write EE,11 then Sr + EF
        bus_start();
        write_byte(8'hEE, ack);
        check("rs_addr_ack", ack, 1'b0);
        write_byte(8'h11, ack);
        check("rs_data_ack", ack, 1'b0);
        check("rs_rx_data", rx_data, 8'h11);
        ld0 = load_pulses;
        tx_data = 8'hA5;
        bus_start();
        check("rs_state_addr", state, 3'd1);
        check("rs_busy_low", busy, 1'b0);
        write_byte(8'hEF, ack);
        check("rs_rd_ack", ack, 1'b0);
        check("rs_state_tx", state, 3'd5);
        check("rs_load", load_pulses - ld0, 1);
        read_byte(rd, 1'b1);
        check("rs_rd_byte", rd, 8'hA5);
        check("rs_rx_kept", rx_data, 8'h11);
        bus_stop();
        check("rs_end_idle", state, 3'd0);

        // Reset mid-byte after 4 address bits of EE
        bus_start();
        clock_bit(1'b1, dummy);
        clock_bit(1'b1, dummy);
        clock_bit(1'b1, dummy);
        clock_bit(1'b0, dummy);
        check("mr_pre_addr", state, 3'd1);
        rst = 1'b1;
        wait_clk(1);
        check("mr_state_idle", state, 3'd0);
        check("mr_sda_oe", sda_oe, 1'b0);
        check("mr_rx_cleared", rx_data, 8'h00);
        rst = 1'b0;
        wait_clk(20);
        check("mr_ignore_bus", state, 3'd0);
        rx0 = rx_pulses;
        bus_start();
        write_byte(8'hEE, ack);
        check("mr_addr_ack", ack, 1'b0);
        write_byte(8'h77, ack);
        check("mr_data_ack", ack, 1'b0);
        check("mr_rx_data", rx_data, 8'h77);
        check("mr_rx_pulses", rx_pulses - rx0, 1);
        bus_stop();
        check("mr_end_idle", state, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h77, is the 7-bit target address; the on-wire address byte is 8'hEE for write and 8'hEF for read.
REQ-002 Parameter SYNC_STAGES, default 2, is the number of synchronizer flops on scl_in and sda_in.
REQ-003 clk  input  1  internal clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 scl_in  input  1  serial clock from bus, asynchronous.
REQ-006 sda_in  input  1  serial data from bus, asynchronous.
REQ-007 sda_oe  output  1  1 = pull SDA low, 0 = release; the block never drives SDA high.
REQ-008 tx_data  input  8  byte returned to the master on a read; sampled at byte load.
REQ-009 tx_load  output  1  one-cycle pulse on the cycle tx_data is sampled.
REQ-010 rx_data  output  8  last byte received on a write.
REQ-011 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-012 busy  output  1  high while addressed, from address ACK until STOP, repeated START or NACK.
REQ-013 state  output  3  current FSM state encoding.

Function
REQ-014 scl_in and sda_in pass through SYNC_STAGES flops plus one history flop; edges are detected on synchronized values.
REQ-015 Operation requires SCL high and SCL low phases of at least 4 clk cycles each.
REQ-016 States and encodings: IDLE=0, ADDR=1, ADDR_ACK=2, RX=3, RX_ACK=4, TX=5, TX_ACK=6, IGNORE=7.
REQ-017 START (SDA fall while SCL high) from any state enters ADDR with bit counter 0 and sda_oe=0; this includes repeated START.
REQ-018 STOP (SDA rise while SCL high) from any state enters IDLE with sda_oe=0.
REQ-019 When START or STOP coincides with an SCL edge event, START/STOP takes priority.
REQ-020 Data is sampled MSB-first on synchronized SCL rising edges; sda_oe changes only on synchronized SCL falling edges.
REQ-021 ADDR shifts in 8 bits; on the 8th rising edge, bits [7:1] are compared with SLAVE_ADDR and bit 0 is latched as the R/W bit (1 = read).
REQ-022 On address mismatch the FSM enters IGNORE, keeps sda_oe=0, and waits for START or STOP.
REQ-023 On address match, sda_oe=1 from the next SCL falling edge; the FSM enters ADDR_ACK and busy goes high.
REQ-024 ADDR_ACK ends at the following SCL falling edge: the FSM enters RX with sda_oe=0 if R/W=0, or enters TX if R/W=1.
REQ-025 On entering TX, tx_data is loaded into the shift register, tx_load pulses, and sda_oe=~bit7 on that same falling edge.
REQ-026 RX samples 8 bits; on the 8th rising edge, rx_data updates and rx_valid pulses for exactly one cycle.
REQ-027 RX_ACK drives sda_oe=1 for one SCL period starting at the next falling edge, then returns to RX; receive is multi-byte without limit.
REQ-028 TX drives sda_oe=~bit on each falling edge for bits 6..0; after bit 0, sda_oe=0 on the next falling edge and the FSM enters TX_ACK.
REQ-029 TX_ACK samples SDA on the rising edge: 0 (ACK) reloads tx_data and returns to TX at the next falling edge; 1 (NACK) enters IGNORE with sda_oe=0.
REQ-030 The bit counter is 3 bits and wraps 7->0 at each byte boundary.
REQ-031 busy is high in ADDR_ACK, RX, RX_ACK, TX and TX_ACK, and low in IDLE, ADDR and IGNORE.

Reset
REQ-032 On rst: state=IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_load=0, busy=0, counter=0; synchronizers preset to 1.
REQ-033 rst asserted mid-transfer releases SDA on the next clk edge; after rst deasserts, the block ignores the bus until the next START.

Structure
REQ-034 Package i2c_pkg holds the state encodings, I2C_READ=1'b1, I2C_WRITE=1'b0, ACK=1'b0 and NACK=1'b1, shared with the master.
REQ-035 Sub-module i2c_sync_edge (synchronizer plus rise/fall detect) is instantiated once each for SCL and SDA.

Verification
REQ-036 Bench case, write: START, 8'hEE, 8'h5A, STOP -> ACK on both bytes, rx_data=8'h5A, one rx_valid pulse, end in IDLE.
REQ-037 Bench case, read: START, 8'hEF, tx_data=8'hC3, master ACK, tx_data=8'h3C, master NACK, STOP -> bus carries C3 then 3C; two tx_load pulses; IGNORE then IDLE.
REQ-038 Bench case, mismatch: START, 8'hA0 -> no ACK (SDA high in 9th clock), sda_oe stays 0, state=IGNORE until STOP.
REQ-039 Bench case, repeated START: write 8'hEE and 8'h11, then repeated START, 8'hEF -> rx_data=8'h11, then TX entered without an intervening STOP.
REQ-040 Bench case, reset mid-byte: rst asserted after 4 bits of 8'hEE -> sda_oe=0 and state=IDLE next cycle; a subsequent full write of 8'h77 is received correctly.
